exec_adder_pipe: RTL

Parametrised two-stage pipelined adder for the MIPS execution stage, the successor to the single-cycle 32-bit execution adder. It performs ADD, SUB, branch-target (a + (b<<2)) and PC+4 operations. The carry chain is split across two register stages, and each stage has a valid/ready handshake with backpressure. It also produces carry, signed-overflow and zero flags, plus a saturating overflow-event counter.

---
 rtl/exec_adder_pipe.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/exec_adder_pipe.sv
// Two-stage pipelined execution adder (ADD/SUB/branch-target/PC+4) with valid/ready
// handshakes, carry/overflow/zero flags and a saturating overflow-event counter.
module exec_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);
  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0] b_eff_s;
  logic             cin_s;
  logic [H:0]       lo_full_s;
  logic             s1_adv_s;
  logic             in_fire_s;
  logic             out_fire_s;

  logic             s1_valid_r;
  logic [H-1:0]     s1_lo_r;
  logic             s1_c_lo_r;
  logic [H-1:0]     s1_a_hi_r;
  logic [H-1:0]     s1_b_hi_r;

  logic [H:0]       hi_full_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;

  logic             s2_valid_r;
  logic [WIDTH-1:0] out_sum_r;
  logic             out_carry_r;
  logic             out_ovf_r;
  logic             out_zero_r;
  logic [CNT_W-1:0] ovf_count_r;

  // Select the effective B operand and carry-in for the requested operation
  always_comb begin
    b_eff_s = in_b;
    cin_s   = 1'b0;
    case (in_op)
      2'b00: begin
        b_eff_s = in_b;
        cin_s   = 1'b0;
      end
      2'b01: begin
        b_eff_s = ~in_b;
        cin_s   = 1'b1;
      end
      2'b10: begin
        b_eff_s = {in_b[WIDTH-3:0], 2'b00};
        cin_s   = 1'b0;
      end
      2'b11: begin
        b_eff_s = {{(WIDTH-3){1'b0}}, 3'b100};
        cin_s   = 1'b0;
      end
      default: begin
        b_eff_s = in_b;
        cin_s   = 1'b0;
      end
    endcase
  end

  assign lo_full_s  = {1'b0, in_a[H-1:0]} + {1'b0, b_eff_s[H-1:0]} + {{H{1'b0}}, cin_s};
  assign s1_adv_s   = s1_valid_r && (!s2_valid_r || out_ready);
  assign in_ready   = !s1_valid_r || s1_adv_s;
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = s2_valid_r && out_ready;

  // The upper half finishes the carry chain; signs come from the top of the registered halves
  assign hi_full_s = {1'b0, s1_a_hi_r} + {1'b0, s1_b_hi_r} + {{H{1'b0}}, s1_c_lo_r};
  assign sum_s     = {hi_full_s[H-1:0], s1_lo_r};
  assign ovf_s     = (s1_a_hi_r[H-1] == s1_b_hi_r[H-1]) && (sum_s[WIDTH-1] != s1_a_hi_r[H-1]);

  // Stage 1: low-half sum and the upper operand halves
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_lo_r    <= {H{1'b0}};
      s1_c_lo_r  <= 1'b0;
      s1_a_hi_r  <= {H{1'b0}};
      s1_b_hi_r  <= {H{1'b0}};
    end else begin
      s1_valid_r <= in_fire_s || (s1_valid_r && !s1_adv_s);
      if (in_fire_s) begin
        s1_lo_r   <= lo_full_s[H-1:0];
        s1_c_lo_r <= lo_full_s[H];
        s1_a_hi_r <= in_a[WIDTH-1:H];
        s1_b_hi_r <= b_eff_s[WIDTH-1:H];
      end
    end
  end

  // Stage 2: full result and flags, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r  <= 1'b0;
      out_sum_r   <= {WIDTH{1'b0}};
      out_carry_r <= 1'b0;
      out_ovf_r   <= 1'b0;
      out_zero_r  <= 1'b0;
    end else begin
      s2_valid_r <= s1_adv_s || (s2_valid_r && !out_ready);
      if (s1_adv_s) begin
        out_sum_r   <= sum_s;
        out_carry_r <= hi_full_s[H];
        out_ovf_r   <= ovf_s;
        out_zero_r  <= (sum_s == {WIDTH{1'b0}});
      end
    end
  end

  // Overflow event counter; clear has priority over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_count_r <= {CNT_W{1'b0}};
    end else if (ovf_clr) begin
      ovf_count_r <= {CNT_W{1'b0}};
    end else if (out_fire_s && out_ovf_r && (ovf_count_r != {CNT_W{1'b1}})) begin
      ovf_count_r <= ovf_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ovf_count_r <= ovf_count_r;
    end
  end

  assign out_valid = s2_valid_r;
  assign out_sum   = out_sum_r;
  assign out_carry = out_carry_r;
  assign out_ovf   = out_ovf_r;
  assign out_zero  = out_zero_r;
  assign ovf_count = ovf_count_r;
endmodule
